store_pack: RTL

- Store-side narrowing unit between the MEM stage and data memory.
- Takes a 32-bit register value plus a store size (sw/sh/sb) and packs it into byte lanes with byte enables on a word-aligned address.
- Buffers packed writes in a small FIFO and drains them to memory over a valid/ready handshake.
- Misaligned or reserved-op stores are flagged and dropped, never written.

---
 rtl/store_pack_pkg.sv | 18 +
 rtl/store_pack_if.sv | 25 ++
 rtl/store_lane_pack.sv | 46 ++++
 rtl/store_pack.sv | 138 +++++++++++++
 4 files changed

// File: rtl/store_pack_pkg.sv
// Shared store-path constants: op encodings, byte-enable patterns and a lane helper.
package store_pack_pkg;

    localparam logic [1:0] OP_SW  = 2'b00;
    localparam logic [1:0] OP_SH  = 2'b01;
    localparam logic [1:0] OP_SB  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic [31:0] rep_byte(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/store_pack_if.sv
// Request and memory-drain handshake bundle for the store packing unit.
interface store_pack_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/store_lane_pack.sv
// Combinational lane packer: places store data on byte lanes and judges alignment.
module store_lane_pack
    import store_pack_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        legal
);

    // Lane placement and legality per store size
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0000_0000;
        legal = 1'b0;
        case (op)
            OP_SW: begin
                be    = BE_WORD;
                wdata = data;
                legal = (addr_lo == 2'b00);
            end
            OP_SH: begin
                if (addr_lo[1]) begin
                    be = BE_HALF_HI;
                end else begin
                    be = BE_HALF_LO;
                end
                wdata = {2{data[15:0]}};
                legal = (addr_lo[0] == 1'b0);
            end
            OP_SB: begin
                be    = BE_BYTE0 << addr_lo;
                wdata = rep_byte(data[7:0]);
                legal = 1'b1;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_pack.sv
// Store narrowing unit: packs requests into lanes, queues them in a small FIFO,
// drains to memory over valid/ready, and flags/drops misaligned or reserved stores.
module store_pack
    import store_pack_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    store_pack_if.slave                bus,
    output logic                       align_err,
    output logic [AW-1:0]              err_addr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [3:0]    lane_be_s;
    logic [31:0]   lane_wdata_s;
    logic          lane_legal_s;
    logic          req_ready_s;
    logic          accept_s;
    logic          push_s;
    logic          bad_s;
    logic          pop_s;
    logic [CW-1:0] count_nxt_s;

    logic [AW-1:0] addr_q_r [DEPTH];
    logic [3:0]    be_q_r   [DEPTH];
    logic [31:0]   data_q_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          mem_valid_r;
    logic          align_err_r;
    logic [AW-1:0] err_addr_r;

    // Explicit compare-and-clear so non-power-of-two depths wrap correctly
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_C) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    store_lane_pack u_lane (
        .op      (bus.req_op),
        .addr_lo (bus.req_addr[1:0]),
        .data    (bus.req_data),
        .be      (lane_be_s),
        .wdata   (lane_wdata_s),
        .legal   (lane_legal_s)
    );

    // No pass-through when full: readiness depends on the stored count only
    assign req_ready_s = (count_r < DEPTH_C);
    assign accept_s    = bus.req_valid && req_ready_s;
    assign push_s      = accept_s && lane_legal_s;
    assign bad_s       = accept_s && !lane_legal_s;
    assign pop_s       = mem_valid_r && bus.mem_ready;

    // Occupancy update from push/pop combination
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q_r[i] <= {AW{1'b0}};
                be_q_r[i]   <= 4'b0000;
                data_q_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            mem_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                addr_q_r[wr_ptr_r] <= {bus.req_addr[AW-1:2], 2'b00};
                be_q_r[wr_ptr_r]   <= lane_be_s;
                data_q_r[wr_ptr_r] <= lane_wdata_s;
                wr_ptr_r           <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r     <= count_nxt_s;
            mem_valid_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    // Error pulse and last bad address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_r <= 1'b0;
            err_addr_r  <= {AW{1'b0}};
        end else begin
            align_err_r <= bad_s;
            if (bad_s) begin
                err_addr_r <= bus.req_addr;
            end
        end
    end

    // Head presentation, forced to zero while empty
    always_comb begin
        if (mem_valid_r) begin
            bus.mem_addr  = addr_q_r[rd_ptr_r];
            bus.mem_be    = be_q_r[rd_ptr_r];
            bus.mem_wdata = data_q_r[rd_ptr_r];
        end else begin
            bus.mem_addr  = {AW{1'b0}};
            bus.mem_be    = 4'b0000;
            bus.mem_wdata = 32'h0000_0000;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.mem_valid = mem_valid_r;
    assign align_err     = align_err_r;
    assign err_addr      = err_addr_r;
    assign count         = count_r;
    assign empty         = (count_r == {CW{1'b0}});

endmodule
